// File: rtl/eespfal_pkg.sv
// Shared types and phase-length defaults for the EESPFAL XOR sequencer.
package eespfal_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StDischarge,
        StEvaluate,
        StRecover
    } state_e;

    localparam int unsigned DefBitSize = 4;
    localparam int unsigned DefDisCyc  = 2;
    localparam int unsigned DefEvalCyc = 3;
    localparam int unsigned DefRecCyc  = 2;
    localparam int unsigned DefCntW    = 8;

    // Counter width able to hold the longest phase length.
    function automatic int unsigned ph_width(input int unsigned a, input int unsigned b,
                                             input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/eespfal_phase_gen.sv
// Macro phase sequencer: IDLE -> DISCHARGE -> EVALUATE -> RECOVER -> IDLE.
module eespfal_phase_gen
    import eespfal_pkg::*;
#(
    parameter int unsigned DIS_CYC  = DefDisCyc,
    parameter int unsigned EVAL_CYC = DefEvalCyc,
    parameter int unsigned REC_CYC  = DefRecCyc
) (
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   start_i,
    output state_e state_o,
    output logic   phase_done_o
);

    localparam int unsigned PhW = ph_width(DIS_CYC, EVAL_CYC, REC_CYC);

    localparam logic [PhW-1:0] DisLoad  = PhW'(DIS_CYC - 1);
    localparam logic [PhW-1:0] EvalLoad = PhW'(EVAL_CYC - 1);
    localparam logic [PhW-1:0] RecLoad  = PhW'(REC_CYC - 1);

    state_e         state_q, state_d;
    logic [PhW-1:0] cnt_q, cnt_d;
    logic           done;

    assign done         = (state_q != StIdle) && (cnt_q == '0);
    assign state_o      = state_q;
    assign phase_done_o = done;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StDischarge;
                    cnt_d   = DisLoad;
                end
            end
            StDischarge: begin
                if (done) begin
                    state_d = StEvaluate;
                    cnt_d   = EvalLoad;
                end else begin
                    cnt_d = cnt_q - PhW'(1);
                end
            end
            StEvaluate: begin
                if (done) begin
                    state_d = StRecover;
                    cnt_d   = RecLoad;
                end else begin
                    cnt_d = cnt_q - PhW'(1);
                end
            end
            StRecover: begin
                if (done) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - PhW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/eespfal_xor_sequencer.sv
// Valid/ready wrapper around a dual-rail EESPFAL XOR macro: encodes operands, sequences
// the macro phases, samples and checks the result, and buffers it for the consumer.
module eespfal_xor_sequencer
    import eespfal_pkg::*;
#(
    parameter int unsigned BIT_SIZE = DefBitSize,
    parameter int unsigned DIS_CYC  = DefDisCyc,
    parameter int unsigned EVAL_CYC = DefEvalCyc,
    parameter int unsigned REC_CYC  = DefRecCyc,
    parameter int unsigned CNT_W    = DefCntW
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [BIT_SIZE-1:0] in_x_i,
    input  logic [BIT_SIZE-1:0] in_k_i,
    input  logic                check_en_i,
    input  logic                cnt_clr_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [BIT_SIZE-1:0] out_s_o,
    output logic                out_fault_o,
    output logic                out_mism_o,
    output logic [CNT_W-1:0]    err_count_o,
    output logic [BIT_SIZE-1:0] ee_clk_o,
    output logic [BIT_SIZE-1:0] ee_dis_o,
    output logic [BIT_SIZE-1:0] ee_x_o,
    output logic [BIT_SIZE-1:0] ee_x_bar_o,
    output logic [BIT_SIZE-1:0] ee_k_o,
    output logic [BIT_SIZE-1:0] ee_k_bar_o,
    input  logic [BIT_SIZE-1:0] ee_s_i,
    input  logic [BIT_SIZE-1:0] ee_s_bar_i
);

    state_e state;
    logic   phase_done;
    logic   accept, res_wr, fault, mism;

    logic                rdy_en_q;
    logic [BIT_SIZE-1:0] x_q, k_q, s_smp_q, s_bar_smp_q;
    logic                chk_q;

    logic                out_valid_q, out_valid_d;
    logic [BIT_SIZE-1:0] out_s_q, out_s_d;
    logic                out_fault_q, out_fault_d;
    logic                out_mism_q, out_mism_d;
    logic [CNT_W-1:0]    err_count_q, err_count_d;

    eespfal_phase_gen #(
        .DIS_CYC  (DIS_CYC),
        .EVAL_CYC (EVAL_CYC),
        .REC_CYC  (REC_CYC)
    ) u_phase_gen (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .start_i      (accept),
        .state_o      (state),
        .phase_done_o (phase_done)
    );

    // rdy_en_q keeps in_ready low while reset is asserted.
    assign in_ready_o = rdy_en_q && (state == StIdle) && (!out_valid_q || out_ready_i);
    assign accept     = in_valid_i && in_ready_o;
    assign res_wr     = (state == StRecover) && phase_done;
    assign fault      = |(s_smp_q ~^ s_bar_smp_q);
    assign mism       = chk_q && (s_smp_q != (x_q ^ k_q));

    always_comb begin
        ee_dis_o   = '1;
        ee_clk_o   = '0;
        ee_x_o     = '0;
        ee_x_bar_o = '0;
        ee_k_o     = '0;
        ee_k_bar_o = '0;
        unique case (state)
            StIdle: ;
            StDischarge: begin
                ee_x_o     = x_q;
                ee_x_bar_o = ~x_q;
                ee_k_o     = k_q;
                ee_k_bar_o = ~k_q;
            end
            StEvaluate: begin
                ee_dis_o   = '0;
                ee_clk_o   = '1;
                ee_x_o     = x_q;
                ee_x_bar_o = ~x_q;
                ee_k_o     = k_q;
                ee_k_bar_o = ~k_q;
            end
            StRecover: ee_dis_o = '0;
            default: ;
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_s_d     = out_s_q;
        out_fault_d = out_fault_q;
        out_mism_d  = out_mism_q;
        err_count_d = err_count_q;
        // A new result write takes priority over the consumer handshake.
        if (res_wr) begin
            out_valid_d = 1'b1;
            out_s_d     = s_smp_q;
            out_fault_d = fault;
            out_mism_d  = mism;
        end else if (out_valid_q && out_ready_i) begin
            out_valid_d = 1'b0;
        end
        if (cnt_clr_i) begin
            err_count_d = '0;
        end else if (res_wr && (fault || mism) && (err_count_q != '1)) begin
            err_count_d = err_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdy_en_q    <= 1'b0;
            x_q         <= '0;
            k_q         <= '0;
            chk_q       <= 1'b0;
            s_smp_q     <= '0;
            s_bar_smp_q <= '0;
            out_valid_q <= 1'b0;
            out_s_q     <= '0;
            out_fault_q <= 1'b0;
            out_mism_q  <= 1'b0;
            err_count_q <= '0;
        end else begin
            rdy_en_q <= 1'b1;
            if (accept) begin
                x_q   <= in_x_i;
                k_q   <= in_k_i;
                chk_q <= check_en_i;
            end
            if ((state == StEvaluate) && phase_done) begin
                s_smp_q     <= ee_s_i;
                s_bar_smp_q <= ee_s_bar_i;
            end
            out_valid_q <= out_valid_d;
            out_s_q     <= out_s_d;
            out_fault_q <= out_fault_d;
            out_mism_q  <= out_mism_d;
            err_count_q <= err_count_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_s_o     = out_s_q;
    assign out_fault_o = out_fault_q;
    assign out_mism_o  = out_mism_q;
    assign err_count_o = err_count_q;

endmodule

// File: tb/tb_eespfal_xor_sequencer.sv
// Randomized self-checking bench for eespfal_xor_sequencer with a behavioural macro model.
module tb_eespfal_xor_sequencer;

    localparam int unsigned W    = 4;
    localparam int unsigned DIS  = 2;
    localparam int unsigned EVAL = 3;
    localparam int unsigned REC  = 2;
    localparam int unsigned CW   = 2;
    localparam int unsigned LAT  = DIS + EVAL + REC + 1;
    localparam int unsigned CMAX = (1 << CW) - 1;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          in_valid_i, in_ready_o, check_en_i, cnt_clr_i;
    logic [W-1:0]  in_x_i, in_k_i;
    logic          out_valid_o, out_ready_i, out_fault_o, out_mism_o;
    logic [W-1:0]  out_s_o;
    logic [CW-1:0] err_count_o;
    logic [W-1:0]  ee_clk_o, ee_dis_o, ee_x_o, ee_x_bar_o, ee_k_o, ee_k_bar_o;
    logic [W-1:0]  ee_s_i, ee_s_bar_i;

    // Macro model: XOR during evaluate, with injectable value errors and rail collisions.
    logic [W-1:0] err_mask, fault_mask;
    assign ee_s_i     = (|ee_clk_o) ? ((ee_x_o ^ ee_k_o) ^ err_mask) : '0;
    assign ee_s_bar_i = (|ee_clk_o) ? (~((ee_x_o ^ ee_k_o) ^ err_mask) ^ fault_mask) : '0;

    int n_checks = 0;
    int n_pass   = 0;
    int cnt_model = 0;

    always #5 clk_i = ~clk_i;

    eespfal_xor_sequencer #(
        .BIT_SIZE (W),
        .DIS_CYC  (DIS),
        .EVAL_CYC (EVAL),
        .REC_CYC  (REC),
        .CNT_W    (CW)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_x_i      (in_x_i),
        .in_k_i      (in_k_i),
        .check_en_i  (check_en_i),
        .cnt_clr_i   (cnt_clr_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_s_o     (out_s_o),
        .out_fault_o (out_fault_o),
        .out_mism_o  (out_mism_o),
        .err_count_o (err_count_o),
        .ee_clk_o    (ee_clk_o),
        .ee_dis_o    (ee_dis_o),
        .ee_x_o      (ee_x_o),
        .ee_x_bar_o  (ee_x_bar_o),
        .ee_k_o      (ee_k_o),
        .ee_k_bar_o  (ee_k_bar_o),
        .ee_s_i      (ee_s_i),
        .ee_s_bar_i  (ee_s_bar_i)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_idle_rails(input string tag);
        check_eq({tag, "_dis"}, ee_dis_o, {W{1'b1}});
        check_eq({tag, "_clk"}, ee_clk_o, '0);
        check_eq({tag, "_rails"}, {ee_x_o, ee_x_bar_o, ee_k_o, ee_k_bar_o}, '0);
    endtask

    // Expected macro drive for cycle 'off' after the accepting edge.
    task automatic check_phase(input int off, input logic [W-1:0] x, input logic [W-1:0] k);
        logic [W-1:0] e_dis, e_clk;
        logic [4*W-1:0] e_rails;
        if (off <= int'(DIS)) begin
            e_dis = '1; e_clk = '0; e_rails = {x, ~x, k, ~k};
        end else if (off <= int'(DIS + EVAL)) begin
            e_dis = '0; e_clk = '1; e_rails = {x, ~x, k, ~k};
        end else begin
            e_dis = '0; e_clk = '0; e_rails = '0;
        end
        check_eq("ph_dis", ee_dis_o, e_dis);
        check_eq("ph_clk", ee_clk_o, e_clk);
        check_eq("ph_rails", {ee_x_o, ee_x_bar_o, ee_k_o, ee_k_bar_o}, e_rails);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!in_ready_o && n < 50) begin
            tick();
            n++;
        end
        check_eq("accept_timeout", (n < 50), 1);
    endtask

    task automatic run_word(input logic [W-1:0] x, input logic [W-1:0] k, input logic chk,
                            input logic [W-1:0] em, input logic [W-1:0] fm, input logic clr,
                            input int hold, input logic hold_valid);
        logic [W-1:0] exp_s;
        logic         exp_f, exp_m;
        err_mask    = em;
        fault_mask  = fm;
        in_x_i      = x;
        in_k_i      = k;
        check_en_i  = chk;
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        #1;
        wait_ready();
        tick();
        in_valid_i = 1'b0;
        in_x_i     = ~x;
        in_k_i     = ~k;
        check_en_i = ~chk;
        for (int off = 1; off < int'(LAT); off++) begin
            check_phase(off, x, k);
            check_eq("busy_out_valid", out_valid_o, 0);
            check_eq("busy_in_ready", in_ready_o, 0);
            if (off == int'(LAT) - 1) cnt_clr_i = clr;
            tick();
        end
        cnt_clr_i = 1'b0;
        exp_s = (x ^ k) ^ em;
        exp_f = (fm != '0);
        exp_m = chk && (em != '0);
        if (clr) cnt_model = 0;
        else if (exp_f || exp_m) cnt_model = (cnt_model < int'(CMAX)) ? cnt_model + 1 : CMAX;
        check_eq("lat_out_valid", out_valid_o, 1);
        check_eq("out_s", out_s_o, exp_s);
        check_eq("out_fault", out_fault_o, exp_f);
        check_eq("out_mism", out_mism_o, exp_m);
        check_eq("err_count", err_count_o, cnt_model);
        for (int h = 0; h < hold; h++) begin
            in_valid_i = hold_valid;
            tick();
            check_eq("hold_valid", out_valid_o, 1);
            check_eq("hold_s", out_s_o, exp_s);
            check_eq("hold_flags", {out_fault_o, out_mism_o}, {exp_f, exp_m});
            check_eq("hold_in_ready", in_ready_o, 0);
            check_idle_rails("hold");
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        #1;
        check_eq("hs_in_ready", in_ready_o, 1);
        tick();
        out_ready_i = 1'b0;
        check_eq("hs_drop", out_valid_o, 0);
    endtask

    initial begin
        int sat_exp[4];
        logic [W-1:0] rx, rk, rem, rfm;
        sat_exp = '{1, 2, 3, 3};
        in_valid_i = 0; check_en_i = 0; cnt_clr_i = 0; out_ready_i = 0;
        in_x_i = '0; in_k_i = '0; err_mask = '0; fault_mask = '0;

        #12;
        check_eq("rst_in_ready", in_ready_o, 0);
        check_eq("rst_out", {out_valid_o, out_s_o, out_fault_o, out_mism_o}, '0);
        check_eq("rst_err_count", err_count_o, 0);
        check_idle_rails("rst");
        #10 rst_ni = 1'b1;
        tick();
        tick();

        run_word(4'hA, 4'h3, 1'b1, 4'h0, 4'h0, 1'b0, 0, 1'b0);
        run_word(4'h6, 4'hC, 1'b1, 4'h0, 4'b0100, 1'b0, 0, 1'b0);

        cnt_clr_i = 1'b1;
        tick();
        cnt_clr_i = 1'b0;
        cnt_model = 0;
        check_eq("idle_clr", err_count_o, 0);

        run_word(4'h5, 4'h5, 1'b0, 4'h1, 4'h0, 1'b0, 0, 1'b0);
        run_word(4'h9, 4'h2, 1'b1, 4'h0, 4'h0, 1'b0, 20, 1'b1);

        for (int i = 0; i < 4; i++) begin
            run_word(W'($urandom), W'($urandom), 1'b1, 4'h0, 4'b0001, 1'b0, 0, 1'b0);
            check_eq("sat_seq", err_count_o, sat_exp[i]);
        end
        run_word(W'($urandom), W'($urandom), 1'b1, 4'h0, 4'b1000, 1'b1, 0, 1'b0);
        check_eq("sat_clr_wins", err_count_o, 0);

        repeat (40) begin
            rx  = W'($urandom);
            rk  = W'($urandom);
            rem = ($urandom_range(3) == 0) ? W'($urandom_range(15, 1)) : '0;
            rfm = ($urandom_range(3) == 0) ? W'($urandom_range(15, 1)) : '0;
            run_word(rx, rk, 1'($urandom), rem, rfm, ($urandom_range(7) == 0),
                     int'($urandom_range(3)), 1'($urandom));
        end

        err_mask = '0; fault_mask = '0;
        in_x_i = 4'hB; in_k_i = 4'h4; check_en_i = 1'b1; in_valid_i = 1'b1;
        #1;
        wait_ready();
        tick();
        in_valid_i = 1'b0;
        repeat (DIS + 1) tick();
        check_eq("pre_rst_clk", ee_clk_o, {W{1'b1}});
        #2 rst_ni = 1'b0;
        #1;
        check_idle_rails("async_rst");
        check_eq("async_rst_valid", out_valid_o, 0);
        check_eq("async_rst_ready", in_ready_o, 0);
        #10 rst_ni = 1'b1;
        tick();
        tick();
        cnt_model = 0;
        run_word(4'h7, 4'h1, 1'b1, 4'h0, 4'h0, 1'b0, 1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
